// File: rtl/dpram_hs_pkg.sv
// Shared constants and types for the handshaked dual-port RAM responder.
// Port-select enum tracks which port wins the next write-write collision.
package dpram_hs_pkg;

    localparam int DEFAULT_AW = 4;
    localparam int DEFAULT_DW = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    function automatic port_sel_e other_port(input port_sel_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/dpram_hs_rsp_slot.sv
// One-entry response register: holds read data until the consumer takes it,
// and tells the request side whether a new read can be loaded this cycle.
module dpram_hs_rsp_slot
    import dpram_hs_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          free
);

    // Free when empty or draining this edge, so a new read can overwrite in place.
    assign free = !rsp_valid || rsp_ready;

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dpram_hs_responder.sv
// Two-port handshaked RAM responder: storage, write-write collision arbitration
// with round-robin priority, and a response slot per port.
module dpram_hs_responder
    import dpram_hs_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic          a_req_we,
    input  logic [AW-1:0] a_req_addr,
    input  logic [DW-1:0] a_req_wdata,
    output logic          a_rsp_valid,
    input  logic          a_rsp_ready,
    output logic [DW-1:0] a_rsp_data,
    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_req_we,
    input  logic [AW-1:0] b_req_addr,
    input  logic [DW-1:0] b_req_wdata,
    output logic          b_rsp_valid,
    input  logic          b_rsp_ready,
    output logic [DW-1:0] b_rsp_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    port_sel_e     prio;
    logic          a_free, b_free;
    logic          collide, a_lose, b_lose;
    logic          a_acc, b_acc;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        collide = 1'b0;
        a_lose  = 1'b0;
        b_lose  = 1'b0;
        if (a_req_valid && b_req_valid && a_req_we && b_req_we &&
            (a_req_addr == b_req_addr) && a_free && b_free) begin
            collide = 1'b1;
            a_lose  = (prio == PORT_B);
            b_lose  = (prio == PORT_A);
        end
    end

    assign a_req_ready = a_free && !a_lose;
    assign b_req_ready = b_free && !b_lose;
    assign a_acc       = a_req_valid && a_req_ready;
    assign b_acc       = b_req_valid && b_req_ready;

    // Reads sample mem combinationally here, so a same-edge write is read-first.
    dpram_hs_rsp_slot #(.DW(DW)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (a_acc && !a_req_we),
        .load_data (mem[a_req_addr]),
        .rsp_ready (a_rsp_ready),
        .rsp_valid (a_rsp_valid),
        .rsp_data  (a_rsp_data),
        .free      (a_free)
    );

    dpram_hs_rsp_slot #(.DW(DW)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (b_acc && !b_req_we),
        .load_data (mem[b_req_addr]),
        .rsp_ready (b_rsp_ready),
        .rsp_valid (b_rsp_valid),
        .rsp_data  (b_rsp_data),
        .free      (b_free)
    );

    // NOTE: storage must clear on reset, so it is built from resettable flops
    // rather than a RAM macro; a plain array without reset would infer RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (a_acc && a_req_we) begin
                mem[a_req_addr] <= a_req_wdata;
            end
            if (b_acc && b_req_we) begin
                mem[b_req_addr] <= b_req_wdata;
            end
        end
    end

    // Priority hands the next collision to whichever port just lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= PORT_A;
        end else if (collide) begin
            prio <= other_port(prio);
        end
    end

endmodule

// File: doc/dpram_hs_responder.md
# dpram_hs_responder

Handshaked responder for the team's dual-port RAM traffic: two independent request ports (A, B) each accept read/write requests under valid/ready, service them against internal storage, and return read data under valid/ready with a one-entry response register per port. It sits between bus-side initiators and storage, resolving same-address write collisions with round-robin priority and throttling each port on response backpressure.

## Interface
Parameters:
- AW, 4, address width; DEPTH = 2**AW
- DW, 8, data width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req_valid  in  1  port A request present
- a_req_ready  out  1  port A request accepted this cycle when valid & ready
- a_req_we  in  1  1 = write, 0 = read
- a_req_addr  in  AW  request address
- a_req_wdata  in  DW  write data
- a_rsp_valid  out  1  port A read data available
- a_rsp_ready  in  1  consumer takes response when valid & ready
- a_rsp_data  out  DW  read data
- b_* identical set for port B

## Operation
- Reset (async assert, sync release): all storage words = 0, a/b_rsp_valid = 0, a/b_rsp_data = 0, prio = A.
- Request accepted on rising edge where req_valid & req_ready. Write: mem[addr] <= wdata, no response. Read: rsp_data <= mem[addr] (old value), rsp_valid <= 1.
- req_ready_x = (!rsp_valid_x | rsp_ready_x) & !lose_x; combinational from rsp state, peer request and prio. Initiators must not gate valid on ready; valid and payload held stable until accepted.
- rsp_valid_x clears on valid & ready with no new read accepted same edge; read accepted while response drains overwrites rsp_data and keeps rsp_valid = 1.
- Collision: both ports valid, both write, equal addr, both otherwise ready -> port == prio wins, other sees req_ready = 0 that cycle; prio toggles to the loser. Only write-write same address collides.
- Cross-port read/write same address same edge: read-first, reader gets pre-write data; no stall.
- Read/read same address: both served, no stall.
- Address is full AW width, no wrap logic needed; every AW value is valid.

## Timing
- Read latency: accept at edge N -> rsp_valid = 1 and rsp_data valid after edge N, consumable at edge N+1.
- Write visible to any read accepted at edge N+1 or later.
- Throughput: one request per port per cycle while rsp_ready held 1 and no collision loss.
- Collision loser accepted no later than next cycle (prio flipped to it).
- rst_n low mid-operation: pending responses discarded immediately, ready outputs reflect reset state (rsp_valid = 0) within same cycle; storage cleared.

## Structure
- Package dpram_hs_pkg: default AW/DW constants, port-select enum (PORT_A, PORT_B) used for prio.
- Sub-module dpram_hs_rsp_slot: one-entry response register (valid, data, ready-upstream logic), instantiated once per port; top holds storage array, collision detect and prio flop.

## Test plan
- Post-reset: A writes 0->AA, 1->BB, 2->CC; B writes 3->DD, 4->EE, 5->FF; A reads 0,1,2 -> AA,BB,CC; B reads 3,4,5 -> DD,EE,FF, each one cycle after accept.
- Same-addr write collision: A writes 7->11, B writes 7->22 same cycle, prio = A -> b_req_ready = 0, A accepted; next cycle B accepted, read 7 -> 22; repeat collision -> B wins first (prio toggled).
- Read-first: mem[9]=33; A writes 9->44 while B reads 9 same edge -> b_rsp_data = 33; subsequent B read 9 -> 44.
- Backpressure: A reads 0 with a_rsp_ready = 0 for 3 cycles -> a_rsp_valid held, a_rsp_data = AA stable, a_req_ready = 0; release -> response consumed, next read accepted same edge.
- Reset mid-op: assert rst_n low while a_rsp_valid = 1 -> a_rsp_valid = 0 immediately; after release read 0 -> 00.
- Back-to-back reads, a_rsp_ready tied 1: addrs 0..5 on consecutive cycles -> one response per cycle, data in order.
